// File: rtl/x86_ucode_pkg.sv
// Shared micro-state codes, opcodes and decode types for the x86-subset
// instruction decoder and its control-signal decoder.
package x86_ucode_pkg;

  localparam logic [7:0] ST_NOP      = 8'd0;
  localparam logic [7:0] ST_AGEN     = 8'd1;
  localparam logic [7:0] ST_MEM_RD   = 8'd2;
  localparam logic [7:0] ST_EXEC_MEM = 8'd3;
  localparam logic [7:0] ST_WB_REG   = 8'd4;
  localparam logic [7:0] ST_WB_DATA  = 8'd5;
  localparam logic [7:0] ST_MEM_WR   = 8'd6;
  localparam logic [7:0] ST_ALU_RR   = 8'd8;
  localparam logic [7:0] ST_MOV_IMM  = 8'd12;
  localparam logic [7:0] ST_JUMP     = 8'd16;

  localparam logic [7:0] OP_ADD_RM_R   = 8'h01;
  localparam logic [7:0] OP_ADD_R_RM   = 8'h03;
  localparam logic [7:0] OP_OR_RM_R    = 8'h09;
  localparam logic [7:0] OP_OR_R_RM    = 8'h0B;
  localparam logic [7:0] OP_GRP1_IMM32 = 8'h81;
  localparam logic [7:0] OP_GRP1_IMM8  = 8'h83;
  localparam logic [7:0] OP_MOV_IMM_LO = 8'hB8;
  localparam logic [7:0] OP_JMP_REL32  = 8'hE9;
  localparam logic [7:0] OP_JMP_REL8   = 8'hEB;

  typedef enum logic [2:0] {
    MOV_IMM,
    ALU_RR,
    ALU_LOAD,
    ALU_RMW,
    JMP
  } instr_class_t;

  typedef enum logic [2:0] {
    P_OPC,
    P_MODRM,
    P_DISP,
    P_IMM,
    EXEC,
    ERR
  } parse_state_t;

  function automatic logic [2:0] seq_len(input instr_class_t cls);
    logic [2:0] len;
    case (cls)
      ALU_LOAD: len = 3'd4;
      ALU_RMW:  len = 3'd5;
      default:  len = 3'd1;
    endcase
    return len;
  endfunction

  function automatic logic [7:0] step_code(input instr_class_t cls, input logic [2:0] step);
    logic [7:0] code;
    code = ST_NOP;
    case (cls)
      MOV_IMM: code = ST_MOV_IMM;
      ALU_RR:  code = ST_ALU_RR;
      JMP:     code = ST_JUMP;
      ALU_LOAD: begin
        case (step)
          3'd0:    code = ST_AGEN;
          3'd1:    code = ST_MEM_RD;
          3'd2:    code = ST_EXEC_MEM;
          default: code = ST_WB_REG;
        endcase
      end
      ALU_RMW: begin
        case (step)
          3'd0:    code = ST_AGEN;
          3'd1:    code = ST_MEM_RD;
          3'd2:    code = ST_EXEC_MEM;
          3'd3:    code = ST_WB_DATA;
          default: code = ST_MEM_WR;
        endcase
      end
      default: code = ST_NOP;
    endcase
    return code;
  endfunction

  // Memory-access codes are held for MEM_CYCLES; every other code lasts one cycle.
  function automatic logic is_mem_wait(input logic [7:0] code);
    return (code == ST_MEM_RD) || (code == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/exec_sequencer.sv
// Steps the micro-state code through the execution sequence of one
// instruction class, holding memory-access codes for MEM_CYCLES cycles.
module exec_sequencer
  import x86_ucode_pkg::*;
#(
  parameter int MEM_CYCLES = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  instr_class_t cls_in,
  output logic [7:0]   state,
  output logic         instr_done
);

  logic         active;
  instr_class_t cls;
  logic [2:0]   step;
  logic [3:0]   wait_cnt;

  logic [7:0]   code;
  logic [3:0]   dur_m1;
  logic         step_end;
  logic         last_step;

  always_comb begin
    code       = step_code(cls, step);
    dur_m1     = is_mem_wait(code) ? 4'(MEM_CYCLES - 1) : 4'd0;
    step_end   = (wait_cnt == dur_m1);
    last_step  = (step == (seq_len(cls) - 3'd1));
    state      = (active && !rst) ? code : ST_NOP;
    instr_done = active && !rst && step_end && last_step;
  end

  // The wait counter restarts at zero on every code change.
  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      cls      <= MOV_IMM;
      step     <= 3'd0;
      wait_cnt <= 4'd0;
    end else if (start) begin
      active   <= 1'b1;
      cls      <= cls_in;
      step     <= 3'd0;
      wait_cnt <= 4'd0;
    end else if (active) begin
      if (step_end) begin
        wait_cnt <= 4'd0;
        if (last_step) active <= 1'b0;
        else           step   <= step + 3'd1;
      end else begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/instr_decode_sequencer.sv
// Byte-serial x86-subset decoder: parses opcode/ModRM/disp/imm over a
// valid/ready stream, then hands the instruction class to exec_sequencer.
//
// state   | meaning
// P_OPC   | waiting for opcode byte; clears ModRM/disp/imm on accept
// P_MODRM | waiting for ModRM byte
// P_DISP  | collecting 1 or 4 displacement bytes
// P_IMM   | collecting 1 or 4 immediate bytes
// EXEC    | exec_sequencer running; no bytes accepted
// ERR     | one-cycle illegal pulse, then back to P_OPC
module instr_decode_sequencer
  import x86_ucode_pkg::*;
#(
  parameter int MEM_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [7:0]  state,
  output logic [7:0]  opcode,
  output logic [7:0]  modrm,
  output logic [7:0]  disp8,
  output logic [31:0] disp32,
  output logic [7:0]  imm8,
  output logic [31:0] imm32,
  output logic        instr_done,
  output logic        illegal
);

  parse_state_t pstate, pnext;
  instr_class_t cls_q, start_cls;
  logic [2:0]   disp_len_q, imm_len_q;
  logic [1:0]   cnt_q;
  logic         accept, start;

  logic         op_ok, op_has_modrm;
  logic [2:0]   op_disp_len, op_imm_len;
  instr_class_t op_cls;

  logic [1:0]   mrm_mod;
  logic [2:0]   mrm_rm;
  logic         mrm_sib;
  logic [2:0]   mrm_disp_len;
  instr_class_t mrm_cls;

  logic         disp_last, imm_last;

  assign byte_ready = !rst && (pstate inside {P_OPC, P_MODRM, P_DISP, P_IMM});
  assign illegal    = !rst && (pstate == ERR);
  assign accept     = byte_valid && byte_ready;
  assign disp_last  = ({1'b0, cnt_q} == (disp_len_q - 3'd1));
  assign imm_last   = ({1'b0, cnt_q} == (imm_len_q - 3'd1));

  // Opcode classification of the byte currently on byte_in.
  always_comb begin
    op_ok        = 1'b0;
    op_has_modrm = 1'b0;
    op_disp_len  = 3'd0;
    op_imm_len   = 3'd0;
    op_cls       = MOV_IMM;
    if (byte_in[7:3] == OP_MOV_IMM_LO[7:3]) begin
      op_ok      = 1'b1;
      op_imm_len = 3'd4;
    end else begin
      case (byte_in)
        OP_ADD_RM_R, OP_ADD_R_RM, OP_OR_RM_R, OP_OR_R_RM: begin
          op_ok        = 1'b1;
          op_has_modrm = 1'b1;
        end
        OP_GRP1_IMM32: begin
          op_ok        = 1'b1;
          op_has_modrm = 1'b1;
          op_imm_len   = 3'd4;
        end
        OP_GRP1_IMM8: begin
          op_ok        = 1'b1;
          op_has_modrm = 1'b1;
          op_imm_len   = 3'd1;
        end
        OP_JMP_REL32: begin
          op_ok       = 1'b1;
          op_disp_len = 3'd4;
          op_cls      = JMP;
        end
        OP_JMP_REL8: begin
          op_ok       = 1'b1;
          op_disp_len = 3'd1;
          op_cls      = JMP;
        end
        default: op_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    mrm_mod = byte_in[7:6];
    mrm_rm  = byte_in[2:0];
    mrm_sib = (mrm_mod != 2'b11) && (mrm_rm == 3'b100);
    case (mrm_mod)
      2'b01:   mrm_disp_len = 3'd1;
      2'b10:   mrm_disp_len = 3'd4;
      2'b00:   mrm_disp_len = (mrm_rm == 3'b101) ? 3'd4 : 3'd0;
      default: mrm_disp_len = 3'd0;
    endcase
    if (mrm_mod == 2'b11)
      mrm_cls = ALU_RR;
    else if ((opcode == OP_ADD_R_RM) || (opcode == OP_OR_R_RM))
      mrm_cls = ALU_LOAD;
    else
      mrm_cls = ALU_RMW;
  end

  always_comb begin
    pnext     = pstate;
    start     = 1'b0;
    start_cls = cls_q;
    case (pstate)
      P_OPC: begin
        if (accept) begin
          if (!op_ok)                  pnext = ERR;
          else if (op_has_modrm)       pnext = P_MODRM;
          else if (op_disp_len != 3'd0) pnext = P_DISP;
          else                         pnext = P_IMM;
        end
      end
      P_MODRM: begin
        start_cls = mrm_cls;
        if (accept) begin
          if (mrm_sib)                   pnext = ERR;
          else if (mrm_disp_len != 3'd0) pnext = P_DISP;
          else if (imm_len_q != 3'd0)    pnext = P_IMM;
          else begin
            pnext = EXEC;
            start = 1'b1;
          end
        end
      end
      P_DISP: begin
        if (accept && disp_last) begin
          if (imm_len_q != 3'd0) pnext = P_IMM;
          else begin
            pnext = EXEC;
            start = 1'b1;
          end
        end
      end
      P_IMM: begin
        if (accept && imm_last) begin
          pnext = EXEC;
          start = 1'b1;
        end
      end
      EXEC:    if (instr_done) pnext = P_OPC;
      ERR:     pnext = P_OPC;
      default: pnext = P_OPC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) pstate <= P_OPC;
    else     pstate <= pnext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode     <= 8'h00;
      modrm      <= 8'h00;
      disp8      <= 8'h00;
      disp32     <= 32'h0;
      imm8       <= 8'h00;
      imm32      <= 32'h0;
      cls_q      <= MOV_IMM;
      disp_len_q <= 3'd0;
      imm_len_q  <= 3'd0;
      cnt_q      <= 2'd0;
    end else if (accept) begin
      case (pstate)
        P_OPC: begin
          opcode     <= byte_in;
          modrm      <= 8'h00;
          disp8      <= 8'h00;
          disp32     <= 32'h0;
          imm8       <= 8'h00;
          imm32      <= 32'h0;
          cls_q      <= op_cls;
          disp_len_q <= op_disp_len;
          imm_len_q  <= op_imm_len;
          cnt_q      <= 2'd0;
        end
        P_MODRM: begin
          modrm      <= byte_in;
          cls_q      <= mrm_cls;
          disp_len_q <= mrm_disp_len;
        end
        P_DISP: begin
          if (disp_len_q == 3'd1) begin
            disp8  <= byte_in;
            disp32 <= {{24{byte_in[7]}}, byte_in};
          end else begin
            disp32[{cnt_q, 3'b000} +: 8] <= byte_in;
          end
          cnt_q <= disp_last ? 2'd0 : cnt_q + 2'd1;
        end
        P_IMM: begin
          if (imm_len_q == 3'd1) imm8 <= byte_in;
          else                   imm32[{cnt_q, 3'b000} +: 8] <= byte_in;
          cnt_q <= imm_last ? 2'd0 : cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  exec_sequencer #(
    .MEM_CYCLES(MEM_CYCLES)
  ) u_exec (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cls_in    (start_cls),
    .state     (state),
    .instr_done(instr_done)
  );

endmodule

// File: doc/instr_decode_sequencer.md
# instr_decode_sequencer

Byte-serial x86-subset instruction decoder and micro-sequencer feeding the datapath control-signal decoder. It consumes instruction bytes over a valid/ready handshake and assembles `opcode`, `modrm`, displacement and immediate fields. It then steps the `state` code through the per-class execution sequence, one code per cycle. It drives exactly the `state`/`opcode`/`modrm`/`disp*`/`imm*` inputs that the control decoder and AGEX datapath consume.

## Interface
- `MEM_CYCLES`, 3: cycles spent in each memory-access state (2 = read, 6 = write); legal range 1–15.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `byte_in` in 8: next instruction byte, in little-endian stream order.
- `byte_valid` in 1: `byte_in` is valid.
- `byte_ready` out 1: decoder accepts a byte; transfer occurs when `byte_valid && byte_ready`.
- `state` out 8: micro-state code to the control decoder; 0 = no operation.
- `opcode` out 8, `modrm` out 8: decoded fields.
- `disp8` out 8, `disp32` out 32, `imm8` out 8, `imm32` out 32: assembled fields.
- `instr_done` out 1: one-cycle pulse during the last execute cycle.
- `illegal` out 1: one-cycle pulse for an unsupported encoding.

## Operation
- **Parse FSM states:** `P_OPC`, `P_MODRM`, `P_DISP`, `P_IMM`, `EXEC`, `ERR`.
- **`byte_ready`:** high only in `P_OPC`, `P_MODRM`, `P_DISP` and `P_IMM`.
- **`P_OPC`:** an accepted opcode is latched, and `modrm`/`disp*`/`imm*` are cleared to 0.
- **Opcode classes:**
  - B8–BF: imm32 only.
  - 01, 03, 09, 0B: ModRM.
  - 81: ModRM + imm32.
  - 83: ModRM + imm8.
  - E9: rel32, captured into `disp32`.
  - EB: rel8, captured into `disp8`, with `disp32` = sign-extended rel8.
  - Anything else goes to `ERR`.
- **ModRM displacement:**
  - mod=11: no displacement.
  - mod=01: disp8, with `disp32` = sign-extended disp8.
  - mod=10: disp32.
  - mod=00, rm=101: disp32.
  - mod=00, other rm: no displacement.
  - mod≠11, rm=100 (SIB form): unsupported, goes to `ERR`.
- **Byte assembly:** multi-byte fields fill little-endian using a 2-bit byte counter; byte k lands in bits [8k+7:8k].
- **`ERR`:** `illegal`=1 for one cycle and `state`=0, then `P_OPC`.
- **Execute sequences** (a state code listed with ×N is held N cycles):
  - MOV B8+r: 12.
  - 01/03/09/0B/81/83 with mod=11: 8.
  - 03/0B with memory operand: 1, 2×`MEM_CYCLES`, 3, 4.
  - 01/09/81/83 with memory operand: 1, 2×`MEM_CYCLES`, 3, 5, 6×`MEM_CYCLES`.
  - E9/EB: 16.
- **Field stability:** outside `EXEC`, `state`=0. All field outputs hold stable from acceptance of the last byte until the next opcode is accepted.

## Timing
- **Reset values:** all outputs 0, including `byte_ready` during `rst`. The FSM enters `P_OPC`, so `byte_ready`=1 in the first cycle after `rst` deasserts.
- **Byte rate:** at most one byte per cycle. A cycle with `byte_valid`=0 stalls parsing with no effect on the fields.
- **Execute start:** `EXEC` begins the cycle after the last byte is accepted; the first state code is visible that cycle.
- **Execute end:** `instr_done` is high in the final `EXEC` cycle. `P_OPC` follows on the next cycle, so there is no overlap of parse and execute.
- **Latency:** from opcode acceptance to `instr_done` = (bytes − 1) + sequence length cycles when there are no bubbles. Example: MOV = 4 + 1 → `instr_done` in the 6th cycle counted from the opcode cycle.
- **Reset mid-operation:** `rst` in any state discards the in-flight instruction. A byte presented in the `rst` cycle is not accepted.
- **Counters:** the memory-wait counter counts 0…`MEM_CYCLES`−1 and reloads on every state change.

## Structure
- **Shared package `x86_ucode_pkg`:**
  - State-code constants 0, 1, 2, 3, 4, 5, 6, 8, 12, 16, shared with the control decoder.
  - Opcode constants.
  - Instruction-class enum: MOV_IMM, ALU_RR, ALU_LOAD, ALU_RMW, JMP.
  - Parse-state enum.
- **Sub-module `exec_sequencer`:** takes class plus a start pulse and produces `state` and `instr_done`. It holds the step index and memory-wait counter.
- **Top module:** holds the parse FSM and the field registers.

## Test plan
- **MOV, no bubbles:** B8 00 00 34 12, continuous valid → `imm32`=0x12340000, `opcode`=B8, `state`=12 for one cycle with `instr_done`, `byte_ready` low in that cycle.
- **Memory-source ALU:** 03 9D FF 00 FF 00 → `modrm`=9D, `disp32`=0x00FF00FF, `state` sequence 1,2,2,2,3,4, `instr_done` with 4.
- **Memory-destination ALU with gaps:** 01 9D FF 00 FF 00, with `byte_valid` gaps between every byte → same fields, sequence 1,2,2,2,3,5,6,6,6; fields unchanged during gaps.
- **Immediate and relative branches:**
  - 83 C0 FF → `imm8`=FF, `state`=8.
  - EB FE → `disp8`=FE, `disp32`=0xFFFFFFFE, `state`=16.
  - E9 05 00 00 00 → `disp32`=5, `state`=16.
- **Illegal encodings:** 0F → `illegal` pulse, `state` stays 0, then B9 … decodes normally. 01 04 (SIB) → `illegal` after the ModRM byte.
- **Reset mid-instruction:** `rst` asserted in step 2 of a memory sequence → next cycle all outputs 0, `byte_ready`=1 after release, next instruction decodes correctly.
